// File: rtl/fxp_dot_engine_if.sv
// Job control, operand stream and result handshake of the fixed-point dot-product engine.
// Latency: none (signal bundle only).
// Backpressure: in_ready_o/res_ready_i carry the valid-ready flow control for the two streams.
interface fxp_dot_engine_if #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 9
);
    logic              start_i;
    logic [LEN_W-1:0]  len_i;
    logic              round_i;
    logic              sat_i;
    logic              busy_o;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] a_i;
    logic [DATA_W-1:0] b_i;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [DATA_W-1:0] res_o;
    logic              ovf_o;

    // Engine side
    modport slave (
        input  start_i, len_i, round_i, sat_i, in_valid_i, a_i, b_i, res_ready_i,
        output busy_o, in_ready_o, res_valid_o, res_o, ovf_o
    );

    // Job issuer / consumer side
    modport master (
        output start_i, len_i, round_i, sat_i, in_valid_i, a_i, b_i, res_ready_i,
        input  busy_o, in_ready_o, res_valid_o, res_o, ovf_o
    );
endinterface

// File: rtl/fxp_dot_engine.sv
// Signed fixed-point dot product over len_i (a,b) pairs, per-job truncate/round and saturate/wrap.
// Latency: result valid the cycle after the last pair transfer (cycle after start for len 0).
// Backpressure: in_ready_o only in ACC; result held until res_ready_i, start ignored until IDLE.
module fxp_dot_engine #(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int ACC_W   = 24,
    parameter int MAX_LEN = 256,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    fxp_dot_engine_if.slave io
);
    localparam int PW = 2 * DATA_W;
    localparam int EW = (ACC_W > PW + 1) ? ACC_W : PW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [LEN_W-1:0]          cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      rnd_q, rnd_d;
    logic                      sat_q, sat_d;
    logic [DATA_W-1:0]         res_q, res_d;
    logic                      ovf_q, ovf_d;

    logic signed [PW-1:0]      prod;
    logic signed [PW:0]        prod_r;
    logic signed [PW:0]        half;
    logic signed [PW:0]        q_full;
    logic signed [EW-1:0]      q_ext;
    logic signed [ACC_W-1:0]   q_acc;
    logic signed [ACC_W-1:0]   acc_sum;
    logic [LEN_W-1:0]          len_clamped;
    logic [LEN_W-1:0]          cnt_inc;
    logic                      fits;
    logic [DATA_W-1:0]         nar_res;
    logic                      nar_ovf;

    // Scaled product of the current pair and the accumulator value it would produce
    always_comb begin
        prod             = $signed(io.a_i) * $signed(io.b_i);
        half             = '0;
        half[FRAC_W-1]   = rnd_q;
        prod_r           = {prod[PW-1], prod} + half;
        q_full           = prod_r >>> FRAC_W;
        q_ext            = EW'(q_full);
        q_acc            = q_ext[ACC_W-1:0];
        acc_sum          = acc_q + q_acc;
        cnt_inc          = cnt_q + LEN_W'(1);
        len_clamped      = (io.len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : io.len_i;
    end

    // Narrow the post-update accumulator to DATA_W; overflow flagged in both modes
    always_comb begin
        fits    = (acc_sum[ACC_W-1:DATA_W-1] == {(ACC_W-DATA_W+1){acc_sum[ACC_W-1]}});
        nar_ovf = !fits;
        nar_res = acc_sum[DATA_W-1:0];
        if (!fits && sat_q) begin
            nar_res = acc_sum[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                       : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    // Next-state and datapath updates; result registers change only on entry to OUT
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rnd_d   = rnd_q;
        sat_d   = sat_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (io.start_i) begin
                    len_d = len_clamped;
                    rnd_d = io.round_i;
                    sat_d = io.sat_i;
                    acc_d = '0;
                    cnt_d = '0;
                    if (len_clamped == '0) begin
                        // Empty job: sum is zero, which always fits
                        res_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = S_OUT;
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (io.in_valid_i) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        res_d   = nar_res;
                        ovf_d   = nar_ovf;
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (io.res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial job
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            rnd_q   <= 1'b0;
            sat_q   <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rnd_q   <= rnd_d;
            sat_q   <= sat_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    assign io.busy_o      = (state_q != S_IDLE);
    assign io.in_ready_o  = (state_q == S_ACC);
    assign io.res_valid_o = (state_q == S_OUT);
    assign io.res_o       = res_q;
    assign io.ovf_o       = ovf_q;

endmodule

// File: tb/tb_fxp_dot_engine.sv
// Directed Q8.8 vectors for fxp_dot_engine with hand-computed results.
// Latency: checks result-valid timing against the last pair transfer.
// Backpressure: exercises result stalls, operand gaps, ignored starts and mid-job reset.
module tb_fxp_dot_engine;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fxp_dot_engine_if #(.DATA_W(16), .LEN_W(9)) io ();

    fxp_dot_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int len, input logic rnd, input logic sat);
        io.start_i = 1'b1;
        io.len_i   = 9'(len);
        io.round_i = rnd;
        io.sat_i   = sat;
        tick();
        io.start_i = 1'b0;
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
        logic ok;
        ok = 1'b0;
        io.in_valid_i = 1'b1;
        io.a_i = a;
        io.b_i = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (io.in_ready_o) ok = 1'b1;
            tick();
        end
        io.in_valid_i = 1'b0;
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic take_res(input string tag, input logic [15:0] exp_res, input logic exp_ovf);
        for (int i = 0; i < 20 && !io.res_valid_o; i++) tick();
        chk({tag, "_valid"}, 32'(io.res_valid_o), 32'd1);
        chk({tag, "_res"},   32'(io.res_o),       32'(exp_res));
        chk({tag, "_ovf"},   32'(io.ovf_o),       32'(exp_ovf));
        io.res_ready_i = 1'b1;
        tick();
        io.res_ready_i = 1'b0;
        chk({tag, "_drop"},  32'(io.res_valid_o), 32'd0);
        chk({tag, "_idle"},  32'(io.busy_o),      32'd0);
    endtask

    // Single-pair rounding vectors: a, b, round, expected
    logic [15:0] t2_a   [4] = '{16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF};
    logic [15:0] t2_b   [4] = '{16'h0080, 16'h0080, 16'h0080, 16'h0080};
    logic        t2_rnd [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] t2_exp [4] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0000};

    initial begin
        io.start_i     = 1'b0;
        io.len_i       = '0;
        io.round_i     = 1'b0;
        io.sat_i       = 1'b0;
        io.in_valid_i  = 1'b0;
        io.a_i         = '0;
        io.b_i         = '0;
        io.res_ready_i = 1'b0;
        rst_n          = 1'b0;
        #2;
        chk("rst_busy",  32'(io.busy_o),      32'd0);
        chk("rst_ready", 32'(io.in_ready_o),  32'd0);
        chk("rst_valid", 32'(io.res_valid_o), 32'd0);
        chk("rst_res",   32'(io.res_o),       32'd0);
        chk("rst_ovf",   32'(io.ovf_o),       32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: 1.5*2 + 0.5*(-1) = 2.5
        start_job(2, 1'b0, 1'b1);
        chk("t1_busy",  32'(io.busy_o),     32'd1);
        chk("t1_ready", 32'(io.in_ready_o), 32'd1);
        send_pair(16'h0180, 16'h0200);
        chk("t1_early", 32'(io.res_valid_o), 32'd0);
        send_pair(16'h0080, 16'hFF00);
        chk("t1_lat",   32'(io.res_valid_o), 32'd1);
        take_res("t1", 16'h0280, 1'b0);

        // 2: truncate is floor, round is half up
        for (int k = 0; k < 4; k++) begin
            start_job(1, t2_rnd[k], 1'b1);
            send_pair(t2_a[k], t2_b[k]);
            take_res($sformatf("t2_%0d", k), t2_exp[k], 1'b0);
        end

        // 3: 4 * 127.0 = 508.0 does not fit Q8.8
        start_job(4, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) send_pair(16'h7F00, 16'h0100);
        take_res("t3_sat", 16'h7FFF, 1'b1);
        start_job(4, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) send_pair(16'h7F00, 16'h0100);
        take_res("t3_wrap", 16'hFC00, 1'b1);

        // 4: empty job
        start_job(0, 1'b0, 1'b1);
        chk("t4_valid", 32'(io.res_valid_o), 32'd1);
        chk("t4_ready", 32'(io.in_ready_o),  32'd0);
        take_res("t4", 16'h0000, 1'b0);

        // 5a: result held under backpressure, start and operands ignored
        start_job(1, 1'b0, 1'b1);
        send_pair(16'h0200, 16'h0300);
        io.start_i    = 1'b1;
        io.len_i      = 9'd1;
        io.in_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t5_res_%0d", k),   32'(io.res_o),       32'h0600);
            chk($sformatf("t5_rdy_%0d", k),   32'(io.in_ready_o),  32'd0);
            chk($sformatf("t5_busy_%0d", k),  32'(io.busy_o),      32'd1);
            chk($sformatf("t5_valid_%0d", k), 32'(io.res_valid_o), 32'd1);
        end
        io.start_i    = 1'b0;
        io.in_valid_i = 1'b0;
        take_res("t5", 16'h0600, 1'b0);
        tick();
        chk("t5_no_job", 32'(io.busy_o), 32'd0);

        // 5b: operand gaps stall the count without losing pairs
        start_job(3, 1'b0, 1'b1);
        send_pair(16'h0100, 16'h0100);
        tick();
        tick();
        chk("t5_gap_busy",  32'(io.busy_o),      32'd1);
        chk("t5_gap_valid", 32'(io.res_valid_o), 32'd0);
        send_pair(16'h0100, 16'h0100);
        tick();
        send_pair(16'h0100, 16'h0100);
        take_res("t5_gap", 16'h0300, 1'b0);

        // 6: reset mid-job discards it; outputs clear asynchronously
        start_job(4, 1'b0, 1'b1);
        send_pair(16'h0100, 16'h0100);
        send_pair(16'h0100, 16'h0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy",  32'(io.busy_o),      32'd0);
        chk("t6_ready", 32'(io.in_ready_o),  32'd0);
        chk("t6_valid", 32'(io.res_valid_o), 32'd0);
        chk("t6_res",   32'(io.res_o),       32'd0);
        chk("t6_ovf",   32'(io.ovf_o),       32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        start_job(1, 1'b0, 1'b1);
        send_pair(16'h0100, 16'h0100);
        take_res("t6_fresh", 16'h0100, 1'b0);

        // 7: len above MAX_LEN clamps to 256 pairs of 1/256 each -> 1.0
        start_job(300, 1'b0, 1'b1);
        for (int k = 0; k < 255; k++) send_pair(16'h0100, 16'h0001);
        chk("t7_not_yet", 32'(io.res_valid_o), 32'd0);
        send_pair(16'h0100, 16'h0001);
        chk("t7_done",  32'(io.res_valid_o), 32'd1);
        chk("t7_ready", 32'(io.in_ready_o),  32'd0);
        take_res("t7", 16'h0100, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
